// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed array serving one read/write request at a time
// after a programmable latency. Optional macro DMEM_RANDOM_LATENCY_EN adds 0..7 LFSR jitter.
module data_memory_responder #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_ADDRESS        = 32,
  parameter int BW_MEM_ADDR       = 10,
  parameter int LATENCY           = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_lsu_valid,
  output logic                                o_lsu_ready,
  input  logic                                i_lsu_r0w1,
  input  logic        [BW_ADDRESS-1:0]        i_lsu_rwaddr,
  input  logic signed [BW_PROCESSOR_DATA-1:0] i_lsu_wdata,
  output logic signed [BW_PROCESSOR_DATA-1:0] o_lsu_rdata
);

  localparam int DEPTH = 1 << BW_MEM_ADDR;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_next;
  logic [8:0] count, count_next;
  logic [8:0] load_value;
  logic       capture, load_rdata;

  logic                                req_wr;
  logic        [BW_MEM_ADDR-1:0]       req_idx;
  logic signed [BW_PROCESSOR_DATA-1:0] req_wdata;
  logic                                req_oor;

  logic                   in_oor;
  logic [BW_MEM_ADDR-1:0] in_idx;
  logic                   cur_wr, cur_oor;
  logic [BW_MEM_ADDR-1:0] cur_idx;
  logic                   unused_addr_lsbs;

  logic signed [BW_PROCESSOR_DATA-1:0] mem [DEPTH];

  assign in_idx           = i_lsu_rwaddr[BW_MEM_ADDR+1:2];
  assign in_oor           = |i_lsu_rwaddr[BW_ADDRESS-1:BW_MEM_ADDR+2];
  assign unused_addr_lsbs = ^i_lsu_rwaddr[1:0];

`ifdef DMEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load_value = 9'(LATENCY - 1) + {6'b0, lfsr[2:0]};
`else
  assign load_value = 9'(LATENCY - 1);
`endif

  // A zero load completes straight from IDLE, so the read source must be the live inputs then.
  assign cur_wr  = capture ? i_lsu_r0w1 : req_wr;
  assign cur_idx = capture ? in_idx     : req_idx;
  assign cur_oor = capture ? in_oor     : req_oor;

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    load_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (i_lsu_valid) begin
          capture    = 1'b1;
          count_next = load_value;
          if (load_value == '0) begin
            state_next = RESP;
            load_rdata = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!i_lsu_valid) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count - 9'd1;
          if (count == 9'd1) begin
            state_next = RESP;
            load_rdata = 1'b1;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      o_lsu_ready <= 1'b0;
      o_lsu_rdata <= '0;
      req_wr      <= 1'b0;
      req_idx     <= '0;
      req_wdata   <= '0;
      req_oor     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      o_lsu_ready <= (state_next == RESP);
      if (capture) begin
        req_wr    <= i_lsu_r0w1;
        req_idx   <= in_idx;
        req_wdata <= i_lsu_wdata;
        req_oor   <= in_oor;
      end
      if (load_rdata && !cur_wr)
        o_lsu_rdata <= cur_oor ? '0 : mem[cur_idx];
    end
  end

  // Storage is not reset; reset forces state out of RESP, which cancels any pending commit.
  always_ff @(posedge clk) begin
    if (state == RESP && req_wr && !req_oor)
      mem[req_idx] <= req_wdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (fixed or random latency build).
module tb_data_memory_responder;

`ifdef DMEM_RANDOM_LATENCY_EN
  localparam int LAT = 2;
  localparam int JIT = 7;
`else
  localparam int LAT = 3;
  localparam int JIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        r0w1;
  logic [31:0] rwaddr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rdata;
  int          lat, lat2;
  logic [31:0] rd;

  data_memory_responder #(
    .BW_PROCESSOR_DATA(32),
    .BW_ADDRESS(32),
    .BW_MEM_ADDR(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_lsu_valid(valid),
    .o_lsu_ready(ready),
    .i_lsu_r0w1(r0w1),
    .i_lsu_rwaddr(rwaddr),
    .i_lsu_wdata(wdata),
    .o_lsu_rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int val, input int lo, input int hi);
    n_checks++;
    assert (val >= lo && val <= hi)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns the count of posedges until ready is seen, and rdata then.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int l, output logic [31:0] r);
    logic seen;
    seen   = 1'b0;
    l      = 0;
    r      = '0;
    r0w1   = w;
    rwaddr = a;
    wdata  = d;
    valid  = 1'b1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        l    = i;
        r    = rdata;
      end else begin
        chk("rdata_hold_wait", rdata, last_rdata);
      end
    end
    valid = 1'b0;
    chk("req_timeout", {31'b0, seen}, 32'd1);
    if (w) chk("rdata_hold_write", r, last_rdata);
    else   last_rdata = r;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; r0w1 = 1'b0; rwaddr = '0; wdata = '0;
    last_rdata = '0;
    idle(2);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    idle(1);

    // fixed latency write then read-back
    do_req(1'b1, 32'h10, 32'h1234_5678, lat, rd);
    chk_range("wr_latency", lat, LAT, LAT + JIT);
    @(negedge clk);
    chk("ready_one_cycle", {31'b0, ready}, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, lat, rd);
    chk_range("rd_latency", lat, LAT, LAT + JIT);
    chk("rd_0x10", rd, 32'h1234_5678);

    idle(1);
    do_req(1'b1, 32'h0, 32'h0BAD_F00D, lat, rd);
    idle(1);
    do_req(1'b1, 32'h40, 32'h1111_1111, lat, rd);
    idle(1);

    // back-to-back: second request presented in the cycle after ready
    do_req(1'b1, 32'h20, 32'hDEAD_BEEF, lat, rd);
    do_req(1'b0, 32'h20, 32'h0, lat2, rd);
    chk_range("b2b_gap", lat2, LAT + 1, LAT + 1 + JIT);
    chk("b2b_rdata", rd, 32'hDEAD_BEEF);

    // address handling
    idle(1);
    do_req(1'b0, 32'h13, 32'h0, lat, rd);
    chk("rd_0x13_alias", rd, 32'h1234_5678);
    idle(1);
    do_req(1'b1, 32'h0001_0000, 32'h5, lat, rd);
    chk_range("oor_wr_latency", lat, LAT, LAT + JIT);
    idle(1);
    do_req(1'b0, 32'h0, 32'h0, lat, rd);
    chk("rd_0x0_untouched", rd, 32'h0BAD_F00D);
    idle(1);
    do_req(1'b0, 32'h0001_0000, 32'h0, lat, rd);
    chk("oor_rd_zero", rd, 32'h0);

    // reset asserted during BUSY of a write
    idle(1);
    r0w1 = 1'b1; rwaddr = 32'h40; wdata = 32'hAAAA_AAAA; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_no_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    rst = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", {31'b0, ready}, 32'd0);
    end
    do_req(1'b0, 32'h40, 32'h0, lat, rd);
    chk("midrst_rd_0x40", rd, 32'h1111_1111);

    // valid dropped during BUSY
    idle(1);
    r0w1 = 1'b0; rwaddr = 32'h10; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_ready", {31'b0, ready}, 32'd0);
      chk("abort_rdata", rdata, 32'h1111_1111);
    end
    do_req(1'b0, 32'h20, 32'h0, lat, rd);
    chk_range("abort_next_latency", lat, LAT, LAT + JIT);
    chk("abort_next_rdata", rd, 32'hDEAD_BEEF);

`ifdef DMEM_RANDOM_LATENCY_EN
    for (int k = 0; k < 8; k++) begin
      idle(1);
      do_req(1'b1, 32'h100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k * 17), lat, rd);
    end
    for (int k = 0; k < 100; k++) begin
      idle(1);
      do_req(1'b0, 32'h100 + 32'(4 * (k % 8)), 32'h0, lat, rd);
      chk_range("rand_latency", lat, 2, 9);
      chk("rand_rdata", rd, 32'hC0DE_0000 + 32'((k % 8) * 17));
    end
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
